// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port grant/rvalid memory.
// Define MISALIGN_TRAP_EN to fault misaligned/illegal requests instead of force-aligning them.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request, stall mirrors req_valid
  // REQ   | memory request asserted until granted
  // WAIT  | load granted, waiting for read data
  // RESP  | one-cycle completion, pipeline released
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;

  logic                  accept, illegal, bad;
  logic [1:0]            size, lane;
  logic [3:0]            wmask;
  logic [DATA_WIDTH-1:0] wdata_rep, shifted, load_fmt;

  logic [1:0]            size_q, size_d, lane_q, lane_d;
  logic                  uns_q, uns_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;

  assign accept = (state_q == IDLE) && req_valid;

  // size: 0 byte, 1 half, 2 word; illegal ops are sized as words
  always_comb begin
    illegal = req_op[1] & (req_op[0] | req_op[2]);
    size    = illegal ? 2'd2 : req_op[1:0];
`ifdef MISALIGN_TRAP_EN
    bad  = illegal | ((size == 2'd1) & req_addr[0]) |
           ((size == 2'd2) & (req_addr[1:0] != 2'b00));
    lane = req_addr[1:0];
`else
    bad = 1'b0;
    case (size)
      2'd0:    lane = req_addr[1:0];
      2'd1:    lane = {req_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase
`endif
    case (size)
      2'd0: begin
        wmask     = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wmask     = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        wmask     = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
    if (!req_we) wmask = 4'b0000;
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_fmt = uns_q ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'd1:    load_fmt = uns_q ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : REQ;
      REQ:     if (mem_gnt) state_d = mem_we_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    stall = req_valid;
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      WAIT:    stall = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // mem_* stay registered so they hold steady while the grant is withheld
  always_comb begin
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      size_d      = size;
      lane_d      = lane;
      uns_d       = req_op[2];
      rsp_rdata_d = '0;
      if (!bad) begin
        mem_we_d    = req_we;
        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_d = wdata_rep;
        mem_wmask_d = wmask;
      end
    end
    if ((state_q == WAIT) && mem_rvalid) rsp_rdata_d = load_fmt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      uns_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      rsp_rdata_q <= '0;
    end else begin
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb misalign_d = accept ? bad : misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a small grant/rvalid memory responder plus per-scenario checks.
// Expectations for faulting requests follow MISALIGN_TRAP_EN when it is defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misalign, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;

  int n_cmp = 0;
  int n_bad = 0;

  // observations from the most recent do_access
  int          obs_lat, obs_reqc;
  logic        obs_to, obs_stall_ok, obs_hold_ok, obs_mis, obs_we;
  logic [31:0] obs_rd, obs_addr, obs_wd;
  logic [3:0]  obs_mask;
  logic [1:0]  obs_post;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and plays the memory side; starts and ends at a negedge.
  task automatic do_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gnt_wait);
    logic pend;
    pend = 1'b0;
    obs_lat = 0; obs_reqc = 0; obs_to = 1'b1; obs_stall_ok = 1'b1; obs_hold_ok = 1'b1;
    obs_rd = 32'h0; obs_mis = 1'b0; obs_addr = 32'h0; obs_wd = 32'h0; obs_mask = 4'h0;
    obs_we = 1'b0;
    cyc();
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    #4;
    if (stall !== 1'b1) obs_stall_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      obs_lat++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
      if (mem_req === 1'b1) begin
        obs_reqc++;
        if (obs_reqc == 1) begin
          obs_addr = mem_addr; obs_mask = mem_wmask; obs_wd = mem_wdata; obs_we = mem_we;
        end else if ({mem_addr, mem_wmask, mem_wdata, mem_we} !== {obs_addr, obs_mask, obs_wd, obs_we}) begin
          obs_hold_ok = 1'b0;
        end
        if (obs_reqc > gnt_wait) begin
          mem_gnt = 1'b1;
          pend = !we;
        end
      end else if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = rdata; pend = 1'b0;
      end
      #4;
      if (rsp_valid === 1'b1) begin
        obs_rd = rsp_rdata; obs_mis = misalign; obs_to = 1'b0;
        break;
      end
      if (stall !== 1'b1) obs_stall_ok = 1'b0;
    end
    // req_valid stays high through RESP, as the pipeline would
    cyc();
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
    #4;
    obs_post = {mem_req, rsp_valid};
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0;
    req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    cyc(); cyc();
    #4;
    n_cmp++; if ({stall, rsp_valid, rsp_rdata, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== 104'h0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", {stall, rsp_valid, rsp_rdata, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}); end
    rst = 1'b0;
  endtask

  task automatic test_store();
    do_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
    n_cmp++; if (obs_to !== 1'b0) begin n_bad++; $display("FAIL sb_timeout got %b want 0", obs_to); end
    n_cmp++; if (obs_lat != 2) begin n_bad++; $display("FAIL sb_latency got %0d want 2", obs_lat); end
    n_cmp++; if (obs_reqc != 1) begin n_bad++; $display("FAIL sb_req_cycles got %0d want 1", obs_reqc); end
    n_cmp++; if (obs_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL sb_addr got %h want 00001000", obs_addr); end
    n_cmp++; if (obs_mask !== 4'b1000) begin n_bad++; $display("FAIL sb_wmask got %b want 1000", obs_mask); end
    n_cmp++; if (obs_wd !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_wdata got %h want ababab ab", obs_wd); end
    n_cmp++; if (obs_we !== 1'b1) begin n_bad++; $display("FAIL sb_we got %b want 1", obs_we); end
    n_cmp++; if (obs_mis !== 1'b0) begin n_bad++; $display("FAIL sb_misalign got %b want 0", obs_mis); end
    n_cmp++; if (obs_stall_ok !== 1'b1) begin n_bad++; $display("FAIL sb_stall got %b want 1", obs_stall_ok); end
    n_cmp++; if (obs_post !== 2'b00) begin n_bad++; $display("FAIL sb_resp_ignores_req got %b want 00", obs_post); end

    do_access(1'b1, 3'b001, 32'h0000_1002, 32'h0000_5678, 32'h0, 0);
    n_cmp++; if ({obs_mask, obs_wd, obs_addr} !== {4'b1100, 32'h5678_5678, 32'h0000_1000}) begin n_bad++; $display("FAIL sh_lanes got %b %h %h want 1100 56785678 00001000", obs_mask, obs_wd, obs_addr); end

    do_access(1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0, 0);
    n_cmp++; if ({obs_mask, obs_wd, obs_addr, obs_lat} !== {4'b1111, 32'hCAFE_F00D, 32'h0000_1004, 32'd2}) begin n_bad++; $display("FAIL sw_lanes got %b %h %h lat %0d want 1111 cafef00d 00001004 lat 2", obs_mask, obs_wd, obs_addr, obs_lat); end
  endtask

  task automatic test_load();
    do_access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_F000, 0);
    n_cmp++; if (obs_lat != 3) begin n_bad++; $display("FAIL lb_latency got %0d want 3", obs_lat); end
    n_cmp++; if (obs_rd !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL lb_rdata got %h want fffffff0", obs_rd); end
    n_cmp++; if ({obs_addr, obs_mask, obs_we} !== {32'h0000_2000, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL lb_mem got %h %b %b want 00002000 0000 0", obs_addr, obs_mask, obs_we); end

    do_access(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_F000, 0);
    n_cmp++; if (obs_rd !== 32'h0000_00F0) begin n_bad++; $display("FAIL lbu_rdata got %h want 000000f0", obs_rd); end

    do_access(1'b0, 3'b000, 32'h0000_2000, 32'h0, 32'h0000_007F, 0);
    n_cmp++; if (obs_rd !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_pos_rdata got %h want 0000007f", obs_rd); end

    do_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 4);
    n_cmp++; if (obs_to !== 1'b0) begin n_bad++; $display("FAIL lhu_timeout got %b want 0", obs_to); end
    n_cmp++; if (obs_reqc != 5) begin n_bad++; $display("FAIL lhu_req_cycles got %0d want 5", obs_reqc); end
    n_cmp++; if ({obs_hold_ok, obs_stall_ok} !== 2'b11) begin n_bad++; $display("FAIL lhu_hold got %b want 11", {obs_hold_ok, obs_stall_ok}); end
    n_cmp++; if (obs_lat != 7) begin n_bad++; $display("FAIL lhu_latency got %0d want 7", obs_lat); end
    n_cmp++; if (obs_rd !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_rdata got %h want 00008001", obs_rd); end

    do_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 0);
    n_cmp++; if (obs_rd !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_rdata got %h want ffff8001", obs_rd); end

    do_access(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h8000_0001, 0);
    n_cmp++; if ({obs_rd, obs_addr} !== {32'h8000_0001, 32'h0000_2004}) begin n_bad++; $display("FAIL lw_rdata got %h %h want 80000001 00002004", obs_rd, obs_addr); end
  endtask

  task automatic test_misalign();
    do_access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h1122_3344, 0);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if ({obs_reqc, obs_lat} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL lw_trap_path got req %0d lat %0d want req 0 lat 1", obs_reqc, obs_lat); end
    n_cmp++; if ({obs_mis, obs_rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL lw_trap_flag got %b %h want 1 00000000", obs_mis, obs_rd); end
`else
    n_cmp++; if ({obs_addr, obs_lat} !== {32'h0000_3000, 32'd3}) begin n_bad++; $display("FAIL lw_align got %h lat %0d want 00003000 lat 3", obs_addr, obs_lat); end
    n_cmp++; if ({obs_mis, obs_rd} !== {1'b0, 32'h1122_3344}) begin n_bad++; $display("FAIL lw_align_data got %b %h want 0 11223344", obs_mis, obs_rd); end
`endif

    do_access(1'b1, 3'b001, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if ({obs_reqc, 31'h0, obs_mis} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL sh_trap got req %0d mis %b want req 0 mis 1", obs_reqc, obs_mis); end
`else
    n_cmp++; if ({obs_mask, obs_wd, obs_addr} !== {4'b0011, 32'hBEEF_BEEF, 32'h0000_1000}) begin n_bad++; $display("FAIL sh_align got %b %h %h want 0011 beefbeef 00001000", obs_mask, obs_wd, obs_addr); end
`endif

    do_access(1'b0, 3'b011, 32'h0000_4001, 32'h0, 32'h8000_0001, 0);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if ({obs_reqc, 31'h0, obs_mis} !== {32'd0, 32'd1}) begin n_bad++; $display("FAIL illegal_trap got req %0d mis %b want req 0 mis 1", obs_reqc, obs_mis); end
`else
    n_cmp++; if ({obs_rd, obs_addr, obs_mis} !== {32'h8000_0001, 32'h0000_4000, 1'b0}) begin n_bad++; $display("FAIL illegal_as_w got %h %h %b want 80000001 00004000 0", obs_rd, obs_addr, obs_mis); end
`endif

    do_access(1'b0, 3'b101, 32'h0000_2003, 32'h0, 32'h8001_FFFF, 0);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if ({obs_mis, obs_rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL lhu_trap got %b %h want 1 00000000", obs_mis, obs_rd); end
`else
    n_cmp++; if (obs_rd !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_align got %h want 00008001", obs_rd); end
`endif
  endtask

  task automatic test_reset_mid();
    // reset while waiting for read data, then a stale rvalid
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h0000_5000;
    #4;
    cyc();
    mem_gnt = 1'b1;
    #4;
    cyc();
    mem_gnt = 1'b0; req_valid = 1'b0; rst = 1'b1;
    #4;
    n_cmp++; if ({stall, mem_req} !== 2'b10) begin n_bad++; $display("FAIL wait_state got %b want 10", {stall, mem_req}); end
    cyc();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #4;
    n_cmp++; if ({stall, rsp_valid, rsp_rdata, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== 104'h0) begin n_bad++; $display("FAIL rst_wait_outputs got %h want 0", {stall, rsp_valid, rsp_rdata, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}); end
    cyc();
    mem_rvalid = 1'b0;
    #4;
    n_cmp++; if ({rsp_valid, rsp_rdata, mem_req} !== 34'h0) begin n_bad++; $display("FAIL late_rvalid got %h want 0", {rsp_valid, rsp_rdata, mem_req}); end

    // reset while requesting a store, then a stale grant
    cyc();
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h0000_6000;
    req_wdata = 32'h5555_AAAA;
    #4;
    cyc();
    req_valid = 1'b0; rst = 1'b1;
    #4;
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_6000}) begin n_bad++; $display("FAIL req_state got %b %h want 1 00006000", mem_req, mem_addr); end
    cyc();
    rst = 1'b0; mem_gnt = 1'b1;
    #4;
    n_cmp++; if ({stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== 71'h0) begin n_bad++; $display("FAIL rst_req_outputs got %h want 0", {stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}); end
    cyc();
    mem_gnt = 1'b0;
    #4;
    n_cmp++; if ({rsp_valid, mem_req} !== 2'b00) begin n_bad++; $display("FAIL late_gnt got %b want 00", {rsp_valid, mem_req}); end
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 3'b000, 32'h0000_7000, 32'h0000_0011, 32'h0, 0);
    do_access(1'b0, 3'b100, 32'h0000_7002, 32'h0, 32'h0055_0000, 1);
    n_cmp++; if ({obs_rd, obs_lat, obs_to} !== {32'h0000_0055, 32'd4, 1'b0}) begin n_bad++; $display("FAIL b2b_lbu got %h lat %0d to %b want 00000055 lat 4 to 0", obs_rd, obs_lat, obs_to); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
